fb_sprite_blitter: RTL

Write-side companion to the VGA framebuffer scan-out. On a start pulse it copies one SPR_W x SPR_H sprite frame from the character RAM into the 240x160 framebuffer RAM at a given pixel position. The sprite frame is selected by player direction. Key-colour pixels are skipped, and pixels falling outside the screen are clipped. It drives the framebuffer write port (write_address, data_In, we) and the character RAM read port, which has 1-cycle registered read latency.

---
 rtl/fb_pkg.sv | 11 +
 rtl/fb_addr_calc.sv | 12 +
 rtl/fb_sprite_blitter.sv | 97 +++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, pixel and address types, and blitter states.
package fb_pkg;
  localparam int FB_W = 240;
  localparam int FB_H = 160;
  localparam int FB_ADDR_W = 19;
  localparam int PIX_W = 24;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  localparam pixel_t KEY_COLOR = 24'hFF00FF;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} blit_state_t;
endpackage

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: row-major framebuffer address and on-screen flag for a pixel coordinate.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [10:0] dx,
  input  logic [10:0] dy,
  output fb_addr_t    addr,
  output logic        on_screen
);
  assign addr = fb_addr_t'(dy) * fb_addr_t'(FB_W) + fb_addr_t'(dx);
  assign on_screen = dx < 11'(FB_W) && dy < 11'(FB_H);
endmodule

// File: rtl/fb_sprite_blitter.sv
// fb_sprite_blitter: copies one sprite frame from character RAM into the framebuffer, skipping key-colour and off-screen pixels.
// Defining FB_BLIT_HFLIP_EN adds the hflip input for horizontally mirrored copies.
module fb_sprite_blitter
  import fb_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [9:0] posX,
  input  logic [9:0] posY,
  input  logic [1:0] playerDir,
`ifdef FB_BLIT_HFLIP_EN
  input  logic       hflip,
`endif
  output logic       busy,
  output logic       done,
  output fb_addr_t   Charread_address,
  input  pixel_t     Chardata_Out,
  output fb_addr_t   FBwrite_address,
  output pixel_t     FBdata_In,
  output logic       FBwe
);
  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  blit_state_t state, next;
  logic [XW-1:0] sx, col;
  logic [YW-1:0] sy;
  logic [9:0] px, py;
  logic [1:0] dir;
  logic wv, on_screen, last, x_wrap;
  logic [10:0] wdx, wdy;
  fb_addr_t waddr, hold_addr;
  pixel_t hold_data;
  assign x_wrap = sx == XW'(SPR_W-1);
  assign last = x_wrap && sy == YW'(SPR_H-1);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = state == IDLE  ? (start ? RUN : IDLE) :
           state == RUN   ? (last ? DRAIN : RUN) :
           state == DRAIN ? DONE : IDLE;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      sx <= '0;
      sy <= '0;
      px <= '0;
      py <= '0;
      dir <= '0;
      wv <= 1'b0;
      wdx <= '0;
      wdy <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        sx <= '0;
        sy <= '0;
        px <= posX;
        py <= posY;
        dir <= playerDir;
      end else if (state == RUN) begin
        sx <= x_wrap ? '0 : sx + 1'b1;
        if (x_wrap) sy <= sy + 1'b1;
      end
      wv <= state == RUN;
      wdx <= {1'b0, px} + 11'(sx);
      wdy <= {1'b0, py} + 11'(sy);
      if (FBwe) begin
        hold_addr <= waddr;
        hold_data <= Chardata_Out;
      end
    end
`ifdef FB_BLIT_HFLIP_EN
  logic hf;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) hf <= 1'b0;
    else if (state == IDLE && start) hf <= hflip;
  assign col = hf ? XW'(SPR_W-1) - sx : sx;
`else
  assign col = sx;
`endif
  fb_addr_calc u_addr (.dx(wdx), .dy(wdy), .addr(waddr), .on_screen(on_screen));
  assign Charread_address = state == RUN ? fb_addr_t'(dir) * fb_addr_t'(SPR_W*SPR_H) +
                            fb_addr_t'(sy) * fb_addr_t'(SPR_W) + fb_addr_t'(col) : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // Outputs hold the last written pixel when idle so the write port never toggles needlessly.
  assign FBwe = wv && on_screen && Chardata_Out != KEY_COLOR;
  assign FBwrite_address = FBwe ? waddr : hold_addr;
  assign FBdata_In = FBwe ? Chardata_Out : hold_data;
endmodule
